// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush,
// data-memory freeze with timeout watchdog, and stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             id_rs_addr_i,
    input  logic [4:0]             id_rt_addr_i,
    input  logic                   id_uses_rt_i,
    input  logic                   ex_memread_i,
    input  logic [4:0]             ex_rt_addr_i,
    input  logic                   branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ready_i,
    input  logic                   stall_cnt_clr_i,
    output logic                   pc_write_o,
    output logic                   ifid_write_o,
    output logic                   ifid_flush_o,
    output logic                   idex_write_o,
    output logic                   idex_bubble_o,
    output logic                   exmem_write_o,
    output logic                   memwb_bubble_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   mem_timeout_o
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       miss;
    logic       load_use;
    logic       freeze;
    logic       stall;

    assign miss = mem_req_i & ~mem_ready_i;

    assign load_use = ex_memread_i & (ex_rt_addr_i != 5'd0) &
                      ((ex_rt_addr_i == id_rs_addr_i) |
                       (id_uses_rt_i & (ex_rt_addr_i == id_rt_addr_i)));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        freeze  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (miss) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                // A dropped request counts as completion.
                if (mem_ready_i | ~mem_req_i) begin
                    state_d = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == TMO) begin
                        state_d = FAULT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            FAULT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall = ~freeze & load_use;

    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = branch_taken_i;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_write_o  = 1'b1;
        memwb_bubble_o = 1'b0;
        unique case (1'b1)
            freeze: begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                ifid_flush_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_write_o  = 1'b0;
                memwb_bubble_o = 1'b1;
            end
            stall: begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                ifid_flush_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_i) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            ifid_flush_o   = 1'b0;
            idex_write_o   = 1'b0;
            idex_bubble_o  = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_write_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    assign mem_timeout_o = rst_i & (state_q == FAULT);

endmodule
